exe_muldiv_iter: RTL
====================

// Module: exe_muldiv_iter
// PURPOSE
//   Parametrised iterative multiply/divide unit for the EXE stage of the 5-stage pipeline.
//   Executes MULT/MULTU/DIV/DIVU over multiple cycles and returns HI/LO results.
//   EXE holds the instruction until done: EXE_over = EXE_valid & (~mul_or_div | done).
//   Results travel to WB on the existing hi_write/lo_write path.
// PARAMETERS
//   WIDTH   32  operand width; legal values 8..64; product is 2*WIDTH bits
//   CNT_W   $clog2(WIDTH)+1  iteration counter width (derived localparam; do not override)
// PORTS
//   clk     in   1      clock; all state updates on posedge
//   resetn  in   1      reset, asynchronous, active-low
//   start   in   1      request; sampled only in IDLE (mul_or_div & EXE_valid)
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start
//   src1    in   WIDTH  multiplicand / dividend; captured with start
//   src2    in   WIDTH  multiplier / divisor; captured with start
//   cancel  in   1      flush (exception/eret); aborts any operation in flight
//   busy    out  1      high from the cycle after start is accepted until done or abort
//   done    out  1      one-cycle pulse; hi/lo are valid in that cycle
//   hi      out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//   lo      out  WIDTH  MULT: product[W-1:0];  DIV: quotient
// BEHAVIOUR
//   Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start & ~cancel -> CALC.
//     Latch the operand magnitudes, or raw operands for unsigned ops.
//     Latch neg_q = src1[W-1]^src2[W-1] and neg_r = src1[W-1] (signed ops only).
//     Latch the div-by-zero flag dz = (src2==0) for DIV/DIVU.
//   CALC: exactly WIDTH cycles; counter runs 0..WIDTH-1.
//     Multiply: radix-2 shift-add, one multiplier bit per cycle.
//     Divide: restoring, one quotient bit per cycle.
//   FIX: one cycle. Signed ops: negate product if neg_q; negate quotient if neg_q; negate remainder if neg_r.
//     Write hi/lo in FIX.
//   DONE: done=1 for one cycle, then IDLE. hi/lo hold until the next FIX.
//   Latency: start sampled at edge N -> done high in cycle N+WIDTH+2; busy high cycles N+1..N+WIDTH+1.
//   done cycle: busy=0. A start in that cycle is ignored; it is accepted in the following IDLE cycle.
//   start while busy or in DONE: ignored; no state change, no error.
//   Divide by zero: lo = all ones, hi = src1 unchanged, for both DIV and DIVU; no sign fix; no trap.
//   Signed overflow (DIV MIN/-1): lo = MIN, hi = 0. This falls out of the magnitude path with no special case.
//   Arithmetic is modulo 2^(2W) for the product and 2^W for quotient/remainder. Remainder sign follows the dividend.
//   cancel: highest priority in every state.
//     Next state IDLE; busy=0 next cycle; done suppressed (also in DONE).
//     hi/lo keep their pre-operation values if cancel arrives before FIX completes.
//     cancel & start in IDLE: start is dropped.
//   resetn low mid-operation: immediate return to reset values; no done pulse.
//   Operand inputs may change after acceptance; only the captured copies are used.
// TESTING
//   MULT  src1=FFFFFFFF src2=00000002 -> done @N+34; hi=FFFFFFFF lo=FFFFFFFE.
//   MULTU src1=FFFFFFFF src2=00000002 -> hi=00000001 lo=FFFFFFFE.
//   DIV   src1=FFFFFFF9 (-7) src2=00000002 -> lo=FFFFFFFD hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//   DIVU  src1=00000007 src2=0 -> lo=FFFFFFFF hi=00000007; busy low at N+34; second start during busy ignored.
//   MULTU 3*5 done (hi=0 lo=F); then DIV 9/2 with cancel at N+5 -> busy=0 @N+6, no done, hi=0 lo=F retained.
//   resetn pulse at N+10 of DIVU -> busy/done/hi/lo=0; next DIVU 64/8 -> lo=8 hi=0 at WIDTH+2 latency.

Source files
------------

// File: rtl/exe_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EXE stage.
// One product or quotient bit per cycle; signs are applied in a final fix-up cycle.
module exe_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | WIDTH iterations of shift-add or restoring divide
  // FIX   | sign correction, hi/lo written
  // DONE  | done pulse, results visible
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   src1_raw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;

  logic               accept;
  logic               sgn;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH:0]   div_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  assign accept = (state == IDLE) & start & ~cancel;
  assign busy   = (state == CALC) | (state == FIX);
  assign done   = (state == DONE) & ~cancel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)        state_nxt = CALC;
      CALC: if (cnt == LAST)  state_nxt = FIX;
      FIX:                    state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                      cnt <= '0;
    else if (state == CALC && !cancel && cnt != LAST) cnt <= cnt + CNT_W'(1);
    else                                              cnt <= '0;
  end

  // Operand capture: signed ops work on magnitudes, signs reapplied in FIX.
  always_comb begin
    sgn  = ~op[0];
    mag1 = (sgn & src1[WIDTH-1]) ? -src1 : src1;
    mag2 = (sgn & src2[WIDTH-1]) ? -src2 : src2;
  end

  // Multiply keeps the multiplier in the low half and shifts the product in from the top.
  // Divide keeps {remainder, dividend/quotient} and shifts left each step.
  always_comb begin
    mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = {1'b0, rem_sh} - {2'b00, opb};
    if (diff[WIDTH+1]) div_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
    else               div_next = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc      <= '0;
      opb      <= '0;
      src1_raw <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
    end else if (accept) begin
      is_div   <= op[1];
      neg_q    <= sgn & (src1[WIDTH-1] ^ src2[WIDTH-1]);
      neg_r    <= sgn & src1[WIDTH-1];
      dz       <= op[1] & (src2 == '0);
      src1_raw <= src1;
      opb      <= op[1] ? mag2 : mag1;
      acc      <= {{(WIDTH+1){1'b0}}, (op[1] ? mag1 : mag2)};
    end else if (state == CALC && !cancel) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  // Divide by zero bypasses the sign fix so hi returns the dividend untouched.
  always_comb begin
    prod     = acc[2*WIDTH-1:0];
    prod_fix = neg_q ? -prod : prod;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        hi_fix = src1_raw;
        lo_fix = '1;
      end else begin
        hi_fix = neg_r ? -rem : rem;
        lo_fix = neg_q ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !cancel) begin
      hi <= hi_fix;
      lo <= lo_fix;
    end
  end

endmodule
